// File: rtl/snap_pkg.sv
// Shared types and default widths for the snapshot capture controller.
package snap_pkg;

   localparam int unsigned DefDataW = 128;
   localparam int unsigned DefAddrW = 10;
   localparam int unsigned DefOfsW  = 32;

   typedef enum logic [2:0] {
      StIdle,
      StArmed,
      StDelay,
      StCapture,
      StDone
   } snap_state_e;

endpackage

// File: rtl/snap_edge_det.sv
// Registered rising-edge detector: rise_o is high for the cycle the input goes 0 -> 1.
module snap_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arm, wait for trigger, skip offset samples, then write
// 2**ADDR_W valid samples to BRAM port A and flag done.
module snap_capture_ctrl
   import snap_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned OFS_W  = DefOfsW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_i,
   input  logic              din_valid_i,
   input  logic              trig_i,
   input  logic              arm_i,
   input  logic [OFS_W-1:0]  offset_i,
   output logic              bram_we_o,
   output logic              bram_en_a_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [DATA_W-1:0] bram_wr_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   wr_count_o
);

   localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);
   localparam logic [OFS_W-1:0]  OfsOne   = OFS_W'(1);

   snap_state_e       state_q;
   logic [OFS_W-1:0]  ofs_cnt_q;
   logic [ADDR_W-1:0] addr_cnt_q;
   logic              bram_we_q;
   logic              bram_en_q;
   logic [ADDR_W-1:0] bram_addr_q;
   logic [DATA_W-1:0] bram_data_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W:0]   wr_count_q;
   logic              arm_rise;

   snap_edge_det u_arm_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (arm_i),
      .rise_o (arm_rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ofs_cnt_q   <= '0;
         addr_cnt_q  <= '0;
         bram_we_q   <= 1'b0;
         bram_en_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_count_q  <= '0;
      end else begin
         bram_en_q <= 1'b1;
         bram_we_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (arm_rise) begin
                  ofs_cnt_q   <= offset_i;
                  addr_cnt_q  <= '0;
                  bram_addr_q <= '0;
                  wr_count_q  <= '0;
                  done_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= StArmed;
               end
            end
            StArmed: begin
               // The trigger sample itself is the first one skipped when offset is non-zero.
               if (trig_i && din_valid_i) begin
                  if (ofs_cnt_q == '0) begin
                     bram_we_q   <= 1'b1;
                     bram_addr_q <= addr_cnt_q;
                     bram_data_q <= din_i;
                     addr_cnt_q  <= addr_cnt_q + AddrOne;
                     wr_count_q  <= wr_count_q + CountOne;
                     state_q     <= StCapture;
                  end else if (ofs_cnt_q == OfsOne) begin
                     state_q <= StCapture;
                  end else begin
                     ofs_cnt_q <= ofs_cnt_q - OfsOne;
                     state_q   <= StDelay;
                  end
               end
            end
            StDelay: begin
               if (din_valid_i) begin
                  if (ofs_cnt_q == OfsOne) begin
                     state_q <= StCapture;
                  end else begin
                     ofs_cnt_q <= ofs_cnt_q - OfsOne;
                  end
               end
            end
            StCapture: begin
               if (din_valid_i) begin
                  bram_we_q   <= 1'b1;
                  bram_addr_q <= addr_cnt_q;
                  bram_data_q <= din_i;
                  addr_cnt_q  <= addr_cnt_q + AddrOne;
                  wr_count_q  <= wr_count_q + CountOne;
                  if (addr_cnt_q == LastAddr) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bram_we_o      = bram_we_q;
   assign bram_en_a_o    = bram_en_q;
   assign bram_addr_o    = bram_addr_q;
   assign bram_wr_data_o = bram_data_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign wr_count_o     = wr_count_q;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl: write log monitored at negedge, checks after each edge.
module tb_snap_capture_ctrl;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 10;
   localparam int OFS_W  = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] din_i = '0;
   logic              din_valid_i = 1'b0;
   logic              trig_i = 1'b0;
   logic              arm_i = 1'b0;
   logic [OFS_W-1:0]  offset_i = '0;
   logic              bram_we_o;
   logic              bram_en_a_o;
   logic [ADDR_W-1:0] bram_addr_o;
   logic [DATA_W-1:0] bram_wr_data_o;
   logic              busy_o;
   logic              done_o;
   logic [ADDR_W:0]   wr_count_o;

   int checks = 0;
   int failures = 0;
   int sample_ctr = 1000;
   int test_id = 0;

   // Cumulative write log, written only by the monitor.
   int          wr_total = 0;
   int          dup_total = 0;
   int          gap_total = 0;
   int          last_bad = 0;
   int          prev_addr = -1;
   int          seen_gen [DEPTH];
   logic [31:0] mem [DEPTH];

   snap_capture_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .OFS_W  (OFS_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .din_i          (din_i),
      .din_valid_i    (din_valid_i),
      .trig_i         (trig_i),
      .arm_i          (arm_i),
      .offset_i       (offset_i),
      .bram_we_o      (bram_we_o),
      .bram_en_a_o    (bram_en_a_o),
      .bram_addr_o    (bram_addr_o),
      .bram_wr_data_o (bram_wr_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .wr_count_o     (wr_count_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && bram_we_o) begin
         wr_total++;
         if (seen_gen[bram_addr_o] == test_id) dup_total++;
         seen_gen[bram_addr_o] = test_id;
         if (bram_addr_o != '0 && int'(bram_addr_o) != prev_addr + 1) gap_total++;
         prev_addr = int'(bram_addr_o);
         mem[bram_addr_o] = bram_wr_data_o[31:0];
         if (int'(bram_addr_o) == DEPTH - 1 && (!done_o || busy_o)) last_bad++;
      end
   end

   // Drive one cycle of inputs just after the edge; outputs then reflect the previous cycle.
   task automatic cyc(input logic v, input logic t, input logic a);
      @(posedge clk);
      #1;
      din_valid_i = v;
      trig_i      = t;
      arm_i       = a;
      din_i       = {4{sample_ctr}};
      if (v) sample_ctr++;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++; if (bram_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", bram_we_o); end
      checks++; if (bram_en_a_o !== 1'b0) begin failures++; $display("FAIL rst_en got=%0b exp=0", bram_en_a_o); end
      checks++; if (bram_addr_o !== '0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", bram_addr_o); end
      checks++; if (bram_wr_data_o !== '0) begin failures++; $display("FAIL rst_data got=%0h exp=0", bram_wr_data_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done_o); end
      checks++; if (wr_count_o !== '0) begin failures++; $display("FAIL rst_wrcnt got=%0d exp=0", wr_count_o); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0);
      checks++; if (bram_en_a_o !== 1'b1) begin failures++; $display("FAIL en_after_rst got=%0b exp=1", bram_en_a_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy_o); end
   endtask

   task automatic test_offset0();
      int w0, d0, g0, b0, k, n;
      test_id = 1;
      w0 = wr_total; d0 = dup_total; g0 = gap_total; b0 = last_bad;
      offset_i = '0;
      cyc(0, 0, 1);
      cyc(1, 0, 0);
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL o0_armed_busy got=%0b exp=1", busy_o); end
      cyc(1, 0, 0);
      k = sample_ctr;
      cyc(1, 1, 0);
      checks++; if (bram_we_o !== 1'b0) begin failures++; $display("FAIL o0_armed_nowr got=%0b exp=0", bram_we_o); end
      cyc(0, 0, 0);
      checks++; if (bram_we_o !== 1'b1) begin failures++; $display("FAIL o0_first_we got=%0b exp=1", bram_we_o); end
      checks++; if (bram_addr_o !== '0) begin failures++; $display("FAIL o0_first_addr got=%0d exp=0", bram_addr_o); end
      checks++; if (bram_wr_data_o !== {4{k}}) begin failures++; $display("FAIL o0_first_data got=%0h exp=%0h", bram_wr_data_o, {4{k}}); end
      checks++; if (wr_count_o !== 11'd1) begin failures++; $display("FAIL o0_first_cnt got=%0d exp=1", wr_count_o); end
      n = 0;
      while (!done_o && n < 1100) begin cyc(1, 0, 0); n++; end
      settle();
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL o0_done got=%0b exp=1", done_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL o0_busy got=%0b exp=0", busy_o); end
      checks++; if (wr_count_o !== 11'd1024) begin failures++; $display("FAIL o0_wrcnt got=%0d exp=1024", wr_count_o); end
      checks++; if (wr_total - w0 != DEPTH) begin failures++; $display("FAIL o0_writes got=%0d exp=%0d", wr_total - w0, DEPTH); end
      checks++; if (dup_total != d0 || gap_total != g0) begin failures++; $display("FAIL o0_contig got=%0d/%0d exp=%0d/%0d", dup_total, gap_total, d0, g0); end
      checks++; if (last_bad != b0) begin failures++; $display("FAIL o0_done_with_last got=%0d exp=%0d", last_bad, b0); end
      checks++; if (mem[DEPTH-1] !== 32'(k + 1023)) begin failures++; $display("FAIL o0_last_data got=%0d exp=%0d", mem[DEPTH-1], k + 1023); end
   endtask

   task automatic test_offset5();
      int w0, d0, g0, s0, n;
      test_id = 2;
      w0 = wr_total; d0 = dup_total; g0 = gap_total;
      offset_i = 32'd5;
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      offset_i = '0;
      s0 = sample_ctr;
      cyc(1, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0);
      checks++; if (wr_count_o !== '0 || bram_we_o !== 1'b0) begin failures++; $display("FAIL o5_skip got=%0d/%0b exp=0/0", wr_count_o, bram_we_o); end
      cyc(1, 0, 0);
      checks++; if (bram_we_o !== 1'b1 || bram_addr_o !== '0) begin failures++; $display("FAIL o5_first got=%0b@%0d exp=1@0", bram_we_o, bram_addr_o); end
      checks++; if (bram_wr_data_o !== {4{s0 + 5}}) begin failures++; $display("FAIL o5_first_data got=%0h exp=%0h", bram_wr_data_o, {4{s0 + 5}}); end
      n = 0;
      while (!done_o && n < 1100) begin cyc(1, 0, 0); n++; end
      settle();
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL o5_done got=%0b exp=1", done_o); end
      checks++; if (wr_total - w0 != DEPTH) begin failures++; $display("FAIL o5_writes got=%0d exp=%0d", wr_total - w0, DEPTH); end
      checks++; if (dup_total != d0 || gap_total != g0) begin failures++; $display("FAIL o5_contig got=%0d/%0d exp=%0d/%0d", dup_total, gap_total, d0, g0); end
      checks++; if (mem[0] !== 32'(s0 + 5)) begin failures++; $display("FAIL o5_addr0 got=%0d exp=%0d", mem[0], s0 + 5); end
      checks++; if (mem[DEPTH-1] !== 32'(s0 + 1028)) begin failures++; $display("FAIL o5_addr1023 got=%0d exp=%0d", mem[DEPTH-1], s0 + 1028); end
   endtask

   task automatic test_valid_gaps();
      int w0, d0, g0, k, n;
      test_id = 3;
      w0 = wr_total; d0 = dup_total; g0 = gap_total;
      offset_i = '0;
      cyc(0, 0, 1);
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      checks++; if (wr_count_o !== '0 || busy_o !== 1'b1) begin failures++; $display("FAIL gap_invalid_trig got=%0d/%0b exp=0/1", wr_count_o, busy_o); end
      k = sample_ctr;
      cyc(1, 1, 0);
      n = 0;
      while (!done_o && n < 2100) begin n++; cyc(n % 2 == 0, 0, 0); end
      settle();
      checks++; if (n != 2047) begin failures++; $display("FAIL gap_span got=%0d exp=2047", n); end
      checks++; if (wr_total - w0 != DEPTH) begin failures++; $display("FAIL gap_writes got=%0d exp=%0d", wr_total - w0, DEPTH); end
      checks++; if (dup_total != d0 || gap_total != g0) begin failures++; $display("FAIL gap_contig got=%0d/%0d exp=%0d/%0d", dup_total, gap_total, d0, g0); end
      checks++; if (mem[DEPTH-1] !== 32'(k + 1023)) begin failures++; $display("FAIL gap_last_data got=%0d exp=%0d", mem[DEPTH-1], k + 1023); end
   endtask

   task automatic test_arm_in_capture();
      int w0, d0, k, n;
      test_id = 4;
      w0 = wr_total; d0 = dup_total;
      offset_i = '0;
      cyc(0, 0, 1);
      k = sample_ctr;
      cyc(1, 1, 0);
      n = 0;
      while (wr_count_o != 11'd300 && n < 400) begin cyc(1, 0, 0); n++; end
      cyc(1, 0, 1);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      checks++; if (busy_o !== 1'b1 || wr_count_o <= 11'd300) begin failures++; $display("FAIL arm_cap_cont got=%0b/%0d exp=1/>300", busy_o, wr_count_o); end
      n = 0;
      while (!done_o && n < 1100) begin cyc(1, 0, 0); n++; end
      settle();
      checks++; if (wr_total - w0 != DEPTH || dup_total != d0) begin failures++; $display("FAIL arm_cap_writes got=%0d/%0d exp=%0d/%0d", wr_total - w0, dup_total, DEPTH, d0); end
      checks++; if (mem[DEPTH-1] !== 32'(k + 1023)) begin failures++; $display("FAIL arm_cap_last got=%0d exp=%0d", mem[DEPTH-1], k + 1023); end
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      checks++; if (done_o !== 1'b0 || wr_count_o !== '0 || busy_o !== 1'b1) begin failures++; $display("FAIL rearm got=%0b/%0d/%0b exp=0/0/1", done_o, wr_count_o, busy_o); end
   endtask

   task automatic test_mid_reset();
      int w0, n;
      test_id = 5;
      cyc(1, 1, 0);
      n = 0;
      while (wr_count_o != 11'd512 && n < 600) begin cyc(1, 0, 0); n++; end
      checks++; if (wr_count_o !== 11'd512) begin failures++; $display("FAIL mid_reach got=%0d exp=512", wr_count_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (bram_we_o !== 1'b0 || bram_en_a_o !== 1'b0) begin failures++; $display("FAIL mid_we_en got=%0b/%0b exp=0/0", bram_we_o, bram_en_a_o); end
      checks++; if (bram_addr_o !== '0 || bram_wr_data_o !== '0) begin failures++; $display("FAIL mid_addr_data got=%0d/%0h exp=0/0", bram_addr_o, bram_wr_data_o); end
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || wr_count_o !== '0) begin failures++; $display("FAIL mid_status got=%0b/%0b/%0d exp=0/0/0", busy_o, done_o, wr_count_o); end
      w0 = wr_total;
      cyc(1, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) cyc(1, i % 3 == 0, 0);
      settle();
      checks++; if (wr_total != w0 || busy_o !== 1'b0) begin failures++; $display("FAIL mid_no_write got=%0d/%0b exp=%0d/0", wr_total, busy_o, w0); end
   endtask

   task automatic test_arm_trig_same();
      int k2;
      test_id = 6;
      offset_i = '0;
      cyc(1, 1, 1);
      cyc(1, 0, 0);
      checks++; if (busy_o !== 1'b1 || bram_we_o !== 1'b0) begin failures++; $display("FAIL same_armed got=%0b/%0b exp=1/0", busy_o, bram_we_o); end
      k2 = sample_ctr;
      cyc(1, 1, 0);
      checks++; if (bram_we_o !== 1'b0 || wr_count_o !== '0) begin failures++; $display("FAIL same_nowr got=%0b/%0d exp=0/0", bram_we_o, wr_count_o); end
      cyc(0, 0, 0);
      checks++; if (bram_we_o !== 1'b1 || bram_addr_o !== '0) begin failures++; $display("FAIL same_start got=%0b@%0d exp=1@0", bram_we_o, bram_addr_o); end
      checks++; if (bram_wr_data_o !== {4{k2}}) begin failures++; $display("FAIL same_data got=%0h exp=%0h", bram_wr_data_o, {4{k2}}); end
   endtask

   initial begin
      test_reset();
      test_offset0();
      test_offset5();
      test_valid_gaps();
      test_arm_in_capture();
      test_mid_reset();
      test_arm_trig_same();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
